// File: rtl/traffic_display_scan_pkg.sv
// traffic_disp_pkg: shared constants and helpers for the traffic display scanner
package traffic_disp_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [1:0] IDX_AL = 2'd0;
  localparam logic [1:0] IDX_AH = 2'd1;
  localparam logic [1:0] IDX_BL = 2'd2;
  localparam logic [1:0] IDX_BH = 2'd3;
  localparam int DEF_DWELL = 4;
  localparam int DEF_BLINK_DIV = 8;
  localparam int DEF_BLINK_THR = 5;
  function automatic logic [7:0] bcd_val(input logic [3:0] h, input logic [3:0] l);
    return {1'b0, h, 3'b0} + {3'b0, h, 1'b0} + {4'b0, l};
  endfunction
endpackage

// File: rtl/traffic_display_scan_if.sv
// traffic_display_scan_if: controller snapshot inputs and display/lamp outputs
interface traffic_display_scan_if;
  logic upd;
  logic [3:0] a_time_l, a_time_h, b_time_l, b_time_h;
  logic a_light, b_light;
  logic [6:0] seg;
  logic [3:0] dig_en;
  logic a_red, a_yel, a_grn, b_red, b_yel, b_grn, fault;
  modport master (
    output upd, a_time_l, a_time_h, b_time_l, b_time_h, a_light, b_light,
    input seg, dig_en, a_red, a_yel, a_grn, b_red, b_yel, b_grn, fault
  );
  modport slave (
    input upd, a_time_l, a_time_h, b_time_l, b_time_h, a_light, b_light,
    output seg, dig_en, a_red, a_yel, a_grn, b_red, b_yel, b_grn, fault
  );
endinterface

// File: rtl/bcd_seg7_enc.sv
// bcd_seg7_enc: BCD digit to active-low {g,f,e,d,c,b,a}, dash for 10..15
module bcd_seg7_enc
  import traffic_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/traffic_display_scan.sv
// traffic_display_scan: snapshot of controller time/lights, muxed 7-seg scan and lamp decode
module traffic_display_scan
  import traffic_disp_pkg::*;
#(
  parameter int DWELL = DEF_DWELL,
  parameter int BLINK_DIV = DEF_BLINK_DIV,
  parameter int BLINK_THR = DEF_BLINK_THR
) (
  input logic CLK,
  input logic reset,
  traffic_display_scan_if.slave bus
);
  localparam int DW = $clog2(DWELL);
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [3:0] al, ah, bl, bh, cur;
  logic alt, blt, phase, a_blink, b_blink, lz;
  logic [DW-1:0] dwell;
  logic [1:0] idx;
  logic [BW-1:0] bcnt;
  logic [6:0] enc, cur_seg;
  bcd_seg7_enc u_enc (.bcd(cur), .seg(enc));
  always_comb begin
    a_blink = phase && alt && al <= 4'd9 && ah <= 4'd9 && int'(bcd_val(ah, al)) < BLINK_THR;
    b_blink = phase && blt && bl <= 4'd9 && bh <= 4'd9 && int'(bcd_val(bh, bl)) < BLINK_THR;
    cur = idx == IDX_AL ? al : idx == IDX_AH ? ah : idx == IDX_BL ? bl : bh;
    // an H zero is only a leading zero when its L partner is a real digit
    lz = idx[0] && cur == 4'd0 && (idx[1] ? bl : al) <= 4'd9;
    cur_seg = (lz || (idx[1] ? b_blink : a_blink)) ? SEG_BLANK : enc;
  end
  always_ff @(posedge CLK) begin
    if (!reset) begin
      {al, ah, bl, bh, alt, blt} <= '0;
      dwell <= '0;
      idx <= '0;
      bcnt <= '0;
      phase <= 1'b0;
      bus.seg <= SEG_BLANK;
      bus.dig_en <= 4'hF;
    end else begin
      if (bus.upd)
        {al, ah, bl, bh, alt, blt} <= {bus.a_time_l, bus.a_time_h, bus.b_time_l, bus.b_time_h, bus.a_light, bus.b_light};
      dwell <= dwell == DW'(DWELL - 1) ? '0 : dwell + 1'b1;
      if (dwell == DW'(DWELL - 1)) idx <= idx + 2'd1;
      bcnt <= bcnt == BW'(BLINK_DIV - 1) ? '0 : bcnt + 1'b1;
      if (bcnt == BW'(BLINK_DIV - 1)) phase <= ~phase;
      bus.dig_en <= dwell == '0 ? 4'hF : ~(4'b1 << idx);
      bus.seg <= dwell == '0 ? SEG_BLANK : cur_seg;
    end
  end
  assign bus.a_grn = alt & ~blt;
  assign bus.a_red = blt;
  assign bus.a_yel = ~alt & ~blt;
  assign bus.b_grn = blt & ~alt;
  assign bus.b_red = alt;
  assign bus.b_yel = ~alt & ~blt;
  assign bus.fault = alt & blt;
endmodule

// File: tb/tb_traffic_display_scan.sv
// tb_traffic_display_scan: scoreboard bench, expected digits queued on each snapshot load
module tb_traffic_display_scan;
  localparam int DWELL = 5;
  localparam int BLINK_DIV = 8;
  localparam logic [3:0] D_AL = 4'hE, D_AH = 4'hD, D_BL = 4'hB, D_BH = 4'h7;
  localparam logic [6:0] BLK = 7'h7F, DASH = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000, S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000;
  typedef struct {
    string tag;
    logic [3:0] den;
    logic [6:0] seg;
    int ph;
  } exp_t;
  logic CLK = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  int n_edges = 0;
  exp_t q[$];
  traffic_display_scan_if bus ();
  traffic_display_scan #(.DWELL(DWELL), .BLINK_DIV(BLINK_DIV), .BLINK_THR(5)) dut (
    .CLK(CLK), .reset(reset), .bus(bus.slave)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) n_edges <= reset ? n_edges + 1 : 0;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int shown_phase();
    return ((n_edges - 1) / BLINK_DIV) % 2;
  endfunction
  task automatic push(input string tag, input logic [3:0] den, input logic [6:0] seg, input int ph);
    exp_t e;
    e.tag = tag;
    e.den = den;
    e.seg = seg;
    e.ph = ph;
    q.push_back(e);
  endtask
  task automatic load(input logic [3:0] ah, al, bh, bl, input logic alt, blt);
    bus.a_time_h = ah;
    bus.a_time_l = al;
    bus.b_time_h = bh;
    bus.b_time_l = bl;
    bus.a_light = alt;
    bus.b_light = blt;
    bus.upd = 1'b1;
    tick();
    bus.upd = 1'b0;
  endtask
  task automatic drain();
    exp_t e;
    logic found;
    while (q.size() > 0) begin
      e = q.pop_front();
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
        tick();
        if (bus.dig_en == e.den && (e.ph < 0 || shown_phase() == e.ph)) found = 1'b1;
      end
      if (found) check(e.tag, bus.seg, e.seg);
      else check({e.tag, "_timeout"}, found, 1);
    end
  endtask
  initial begin
    logic found;
    reset = 1'b0;
    bus.upd = 1'b0;
    {bus.a_time_l, bus.a_time_h, bus.b_time_l, bus.b_time_h} = '0;
    {bus.a_light, bus.b_light} = 2'b00;
    tick();
    tick();
    check("rst_seg", bus.seg, BLK);
    check("rst_den", bus.dig_en, 4'hF);
    check("rst_lamps", {bus.a_red, bus.a_yel, bus.a_grn, bus.b_red, bus.b_yel, bus.b_grn, bus.fault}, 7'b0100100);
    reset = 1'b1;
    tick();
    check("rel_e1", bus.dig_en, 4'hF);
    for (int i = 2; i <= DWELL; i++) begin
      tick();
      check("rel_idx0", bus.dig_en, 4'hE);
    end
    tick();
    check("rel_gap1", bus.dig_en, 4'hF);
    load(4'd3, 4'd7, 4'd0, 4'd0, 1'b1, 1'b0);
    check("t1_lamps", {bus.a_red, bus.a_yel, bus.a_grn, bus.b_red, bus.b_yel, bus.b_grn, bus.fault}, 7'b0011000);
    push("t1_al", D_AL, S7, -1);
    push("t1_ah", D_AH, S3, -1);
    push("t1_bl", D_BL, S0, -1);
    push("t1_bh_lz", D_BH, BLK, -1);
    push("t1_al_ph1", D_AL, S7, 1);
    push("t1_ah_ph1", D_AH, S3, 1);
    drain();
    load(4'd0, 4'd4, 4'd0, 4'd0, 1'b0, 1'b1);
    check("t2_lamps", {bus.a_red, bus.a_yel, bus.a_grn, bus.b_red, bus.b_yel, bus.b_grn, bus.fault}, 7'b1000010);
    push("t2_ah_lz", D_AH, BLK, 0);
    push("t2_al_ph1", D_AL, S4, 1);
    push("t2_al_ph0", D_AL, S4, 0);
    drain();
    load(4'd0, 4'd4, 4'd0, 4'd3, 1'b0, 1'b1);
    push("t3_bl_ph0", D_BL, S3, 0);
    push("t3_bl_ph1", D_BL, BLK, 1);
    push("t3_bh_lz", D_BH, BLK, -1);
    push("t3_bl_ph0b", D_BL, S3, 0);
    push("t3_bl_ph1b", D_BL, BLK, 1);
    drain();
    load(4'd0, 4'd4, 4'd0, 4'd5, 1'b0, 1'b1);
    push("thr_bl_ph1", D_BL, S5, 1);
    drain();
    load(4'd0, 4'd12, 4'd0, 4'd5, 1'b0, 1'b0);
    push("t4_al_dash", D_AL, DASH, -1);
    push("t4_ah_ph0", D_AH, S0, 0);
    push("t4_ah_ph1", D_AH, S0, 1);
    drain();
    bus.upd = 1'b1;
    bus.a_light = 1'b1;
    bus.b_light = 1'b0;
    tick();
    check("hold_a_grn", bus.a_grn, 1'b1);
    bus.a_light = 1'b0;
    bus.b_light = 1'b1;
    tick();
    check("hold_b_grn", {bus.a_red, bus.b_grn}, 2'b11);
    bus.upd = 1'b0;
    load(4'd0, 4'd12, 4'd0, 4'd5, 1'b1, 1'b1);
    check("t5_lamps", {bus.a_red, bus.a_yel, bus.a_grn, bus.b_red, bus.b_yel, bus.b_grn, bus.fault}, 7'b1001001);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (bus.dig_en == D_BL) found = 1'b1;
    end
    check("t6_reach_idx2", found, 1'b1);
    reset = 1'b0;
    tick();
    check("t6_seg", bus.seg, BLK);
    check("t6_den", bus.dig_en, 4'hF);
    check("t6_lamps", {bus.a_red, bus.a_yel, bus.a_grn, bus.b_red, bus.b_yel, bus.b_grn, bus.fault}, 7'b0100100);
    reset = 1'b1;
    tick();
    check("t6_e1", bus.dig_en, 4'hF);
    tick();
    check("t6_e2", bus.dig_en, 4'hE);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/traffic_display_scan.md
# traffic_display_scan

Display-side consumer of the traffic-light controller's time and light outputs. It snapshots the four BCD countdown digits and the two light flags on an update strobe. It drives a 4-digit multiplexed active-low 7-segment display with leading-zero blanking, invalid-digit dash and end-of-phase blinking. It also decodes the light flags into per-direction red/yellow/green lamp drives.

## Interface
- DWELL, 4: cycles each digit is scanned; minimum 2.
- BLINK_DIV, 8: cycles per blink half-period.
- BLINK_THR, 5: integer; green-direction digits blink while remaining time is below this value.

- CLK  in  1  clock; all state changes on posedge.
- reset  in  1  reset, synchronous, active-low.
- upd  in  1  snapshot strobe, sampled at posedge.
- a_time_l, a_time_h, b_time_l, b_time_h  in  4 each  BCD countdown digits.
- a_light, b_light  in  1 each  1 = that direction green.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dig_en  out  4  digit enables, active-low one-hot, registered; bit0=A_L, bit1=A_H, bit2=B_L, bit3=B_H.
- a_red, a_yel, a_grn, b_red, b_yel, b_grn  out  1 each  lamp drives, active-high.
- fault  out  1  both light flags set in the snapshot.

## Operation
- Snapshot: upd=1 at an edge loads all six inputs into snapshot registers. Otherwise the snapshot holds. The display and lamps use only the snapshot.
- Scan: dwell counter 0..DWELL-1 and digit index 0..3. At dwell=DWELL-1, dwell wraps to 0 and the index increments mod 4. One frame lasts 4*DWELL cycles.
- Output register, computed from pre-edge dwell/index/snapshot:
  - dwell=0: dig_en=4'hF and seg=7'h7F (anti-ghost gap).
  - Otherwise: dig_en=~(1<<idx) and seg=encode(current digit).
- Encoding, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 produce a dash, 0111111.
- Leading zero: an H digit of 0 is blanked (7'h7F) only when the same direction's L digit is valid (<=9).
- Blink: the phase bit toggles every BLINK_DIV cycles. A direction's digits are blanked while all of these hold:
  - phase=1
  - that direction's light=1
  - both its digits are valid
  - 10*H+L < BLINK_THR
- Lamps, combinational from snapshot:
  - grn = own light.
  - red = ~own & other.
  - yel = ~own & ~other.
  - If both lights are 1: fault=1, both red=1, greens=0, yellows=0.

## Timing
- Reset edge: snapshot=0, dwell=0, idx=0, phase=0, seg=7'h7F, dig_en=4'hF. Lamps show a_yel=b_yel=1, others 0, fault=0.
- Reset mid-frame: same values at that edge; the scan restarts at idx 0.
- After reset release: dig_en is F at edge 1, E at edges 2..DWELL, and F again at the start of idx 1.
- upd latency:
  - Lamps and fault change in the cycle after the capture edge.
  - seg reflects new data at the next output-register update of that digit. There is no scan restart.
- upd held high: the snapshot tracks the inputs every cycle.
- Counters wrap silently; there is no overflow state.

## Structure
- Package traffic_disp_pkg holds:
  - Constants SEG_BLANK=7'h7F and SEG_DASH=7'b0111111.
  - Digit-index localparams IDX_AL/AH/BL/BH.
  - Default DWELL/BLINK_DIV/BLINK_THR values.
- Sub-module bcd_seg7_enc: combinational 4-bit BCD to active-low 7-seg, with dash for 10..15.
- The top level holds the snapshot, scan counters, blink divider, output registers and lamp decode.

## Test plan
- Reset, then upd with a=3/7 (H/L), b=0/0, a_light=1, b_light=0:
  - idx0 seg=1111000, idx1 seg=0110000.
  - idx2 seg=1000000, idx3 seg=7F (leading-zero blank).
  - a_grn=1, b_red=1; no blink because 37 >= 5.
- upd with a=0/4, a_light=0, b_light=1: A_H blanked, A_L=0011001, a_red=1, b_grn=1, no A blink.
- upd with b=0/3, b_light=1: B_L shows 0110000 while phase=0. B_L shows 7F during each 8-cycle phase=1 window.
- upd with a_time_l=12, a_time_h=0: A_L=0111111 (dash), A_H=1000000 (not blanked).
- upd with a_light=b_light=1: next cycle fault=1, a_red=b_red=1, greens=0, yellows=0.
- Assert reset low mid-frame at idx 2: next edge seg=7F, dig_en=F, a_yel=b_yel=1. After release the scan restarts at dig_en=E.
